// File: rtl/mem_map_pkg.sv
// Memory map constants and port-B read tag type shared by the port-B arbiter slice.
package mem_map_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 24;

  localparam logic [ADDR_W-1:0] IMG_ROM_LAST = 17'd89999;
  localparam logic [ADDR_W-1:0] SIN_FIRST    = 17'd90000;
  localparam logic [ADDR_W-1:0] SIN_LAST     = 17'd90299;
  localparam logic [ADDR_W-1:0] RAM_BASE     = 17'd90300;

  typedef struct packed {
    logic valid;
    logic id;
    logic unmapped;
  } rd_tag_t;

  // Port B has no path to the sin ROM; reads there are answered with zero.
  function automatic logic in_sin_window(input logic [ADDR_W-1:0] addr);
    return (addr >= SIN_FIRST) && (addr <= SIN_LAST);
  endfunction

endpackage

// File: rtl/port_b_arbiter_if.sv
// Two-requester read bus plus the memory-stage port B connection.
interface port_b_arbiter_if;
  import mem_map_pkg::*;

  logic              req_0;
  logic              req_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic              gnt_0;
  logic              gnt_1;
  logic              rvalid_0;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_rdata_b;
  logic              err_unmapped;

  modport master (
    output req_0, req_1, addr_0, addr_1, mem_rdata_b,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, mem_addr_b, err_unmapped
  );

  modport slave (
    input  req_0, req_1, addr_0, addr_1, mem_rdata_b,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, mem_addr_b, err_unmapped
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the port-B read latency.
module rd_tag_pipe
  import mem_map_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/port_b_arbiter.sv
// Shares memory port B between pixel fetch (0) and debug dump (1), one read per cycle,
// and routes each returned word back to its issuer.
module port_b_arbiter
  import mem_map_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int PRIO_MODE  = 0,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  port_b_arbiter_if.slave   bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              gnt_0_c;
  logic              gnt_1_c;
  logic              xfer;
  logic              last_gnt;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] rdata_0_q;
  logic [DATA_W-1:0] rdata_1_q;
  logic [DATA_W-1:0] ret_word;
  logic              rvalid_0_c;
  logic              rvalid_1_c;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  always_comb begin
    gnt_0_c = 1'b0;
    gnt_1_c = 1'b0;
    if (!rst) begin
      if (PRIO_MODE == 0) begin
        if (bus.req_0 && bus.req_1) begin
          gnt_0_c = last_gnt;
          gnt_1_c = !last_gnt;
        end else begin
          gnt_0_c = bus.req_0;
          gnt_1_c = bus.req_1;
        end
      end else begin
        // Requester 1 gets through alone, or once it has waited MAX_WAIT cycles.
        if (bus.req_1 && (!bus.req_0 || wait_cnt == MAX_WAIT_C)) gnt_1_c = 1'b1;
        else                                                     gnt_0_c = bus.req_0;
      end
    end
  end

  assign xfer       = gnt_0_c || gnt_1_c;
  assign mem_addr_c = gnt_1_c ? bus.addr_1 : (gnt_0_c ? bus.addr_0 : mem_addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      wait_cnt   <= 8'd0;
      mem_addr_q <= '0;
    end else begin
      if (xfer) last_gnt <= gnt_1_c;
      if (!bus.req_1 || gnt_1_c) wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      mem_addr_q <= mem_addr_c;
    end
  end

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = xfer;
    tag_in.id       = gnt_1_c;
    tag_in.unmapped = in_sin_window(mem_addr_c);
  end

  rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gate by rst so a return landing in the reset cycle is also dropped.
  assign rvalid_0_c = tag_out.valid && !tag_out.id && !rst;
  assign rvalid_1_c = tag_out.valid &&  tag_out.id && !rst;
  assign ret_word   = tag_out.unmapped ? '0 : bus.mem_rdata_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      if (rvalid_0_c) rdata_0_q <= ret_word;
      if (rvalid_1_c) rdata_1_q <= ret_word;
    end
  end

  assign bus.gnt_0        = gnt_0_c;
  assign bus.gnt_1        = gnt_1_c;
  assign bus.rvalid_0     = rvalid_0_c;
  assign bus.rvalid_1     = rvalid_1_c;
  assign bus.rdata_0      = rvalid_0_c ? ret_word : rdata_0_q;
  assign bus.rdata_1      = rvalid_1_c ? ret_word : rdata_1_q;
  assign bus.mem_addr_b   = mem_addr_c;
  assign bus.err_unmapped = tag_out.valid && tag_out.unmapped && !rst;

endmodule

// File: tb/tb_port_b_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters against a 2-cycle port-B memory model.
module tb_port_b_arbiter;
  import mem_map_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  port_b_arbiter_if if_rr ();
  port_b_arbiter_if if_fp ();

  port_b_arbiter #(.RD_LATENCY(2), .PRIO_MODE(0), .MAX_WAIT(15)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr)
  );

  port_b_arbiter #(.RD_LATENCY(2), .PRIO_MODE(1), .MAX_WAIT(3)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (if_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 24'hABCDDF + {7'd0, a};
  endfunction

  // Port B: address register then output register.
  logic [ADDR_W-1:0] a1_rr;
  logic [ADDR_W-1:0] a1_fp;
  always @(posedge clk) begin
    a1_rr             <= if_rr.mem_addr_b;
    if_rr.mem_rdata_b <= mem_word(a1_rr);
    a1_fp             <= if_fp.mem_addr_b;
    if_fp.mem_rdata_b <= mem_word(a1_fp);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if_rr.req_0 = 1'b0; if_rr.req_1 = 1'b0; if_rr.addr_0 = '0; if_rr.addr_1 = '0;
    if_fp.req_0 = 1'b0; if_fp.req_1 = 1'b0; if_fp.addr_0 = '0; if_fp.addr_1 = '0;
    repeat (2) cyc();

    // Grants held off while in reset
    if_rr.req_0 = 1'b1; if_rr.req_1 = 1'b1; #1;
    chk("rst_gnt_0", 32'(if_rr.gnt_0), 32'd0);
    chk("rst_gnt_1", 32'(if_rr.gnt_1), 32'd0);

    cyc(); rst = 1'b0; if_rr.req_0 = 1'b0; if_rr.req_1 = 1'b0; #1;
    chk("rst_rvalid_0", 32'(if_rr.rvalid_0), 32'd0);
    chk("rst_rdata_0", 32'(if_rr.rdata_0), 32'd0);
    chk("rst_rdata_1", 32'(if_rr.rdata_1), 32'd0);
    chk("rst_mem_addr", 32'(if_rr.mem_addr_b), 32'd0);
    chk("rst_err", 32'(if_rr.err_unmapped), 32'd0);

    // Round-robin with both requesting for 6 cycles: 0,1,0,1,0,1
    for (int i = 0; i < 8; i++) begin
      cyc();
      if_rr.req_0 = (i < 6); if_rr.req_1 = (i < 6);
      if_rr.addr_0 = 17'h00100; if_rr.addr_1 = 17'h00200; #1;
      chk("rr_gnt_0", 32'(if_rr.gnt_0), 32'((i < 6) && (i % 2 == 0)));
      chk("rr_gnt_1", 32'(if_rr.gnt_1), 32'((i < 6) && (i % 2 == 1)));
      if (i < 6) chk("rr_mem_addr", 32'(if_rr.mem_addr_b), (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_rvalid_0", 32'(if_rr.rvalid_0), 32'((i >= 2) && (i % 2 == 0)));
      chk("rr_rvalid_1", 32'(if_rr.rvalid_1), 32'((i >= 2) && (i % 2 == 1)));
      if (i >= 2 && i % 2 == 0) chk("rr_rdata_0", 32'(if_rr.rdata_0), 32'h00ABCEDF);
      if (i >= 2 && i % 2 == 1) chk("rr_rdata_1", 32'(if_rr.rdata_1), 32'h00ABCFDF);
    end

    // Requester 0 alone at 0x10
    cyc(); if_rr.req_0 = 1'b1; if_rr.addr_0 = 17'h00010; #1;
    chk("r0_gnt_0", 32'(if_rr.gnt_0), 32'd1);
    chk("r0_gnt_1", 32'(if_rr.gnt_1), 32'd0);
    chk("r0_mem_addr", 32'(if_rr.mem_addr_b), 32'h10);
    cyc(); if_rr.req_0 = 1'b0; #1;
    chk("r0_rvalid_early", 32'(if_rr.rvalid_0), 32'd0);
    cyc(); #1;
    chk("r0_rvalid_0", 32'(if_rr.rvalid_0), 32'd1);
    chk("r0_rdata_0", 32'(if_rr.rdata_0), 32'h00ABCDEF);
    chk("r0_rvalid_1", 32'(if_rr.rvalid_1), 32'd0);
    cyc(); #1;
    chk("r0_rvalid_late", 32'(if_rr.rvalid_0), 32'd0);
    chk("r0_rdata_hold", 32'(if_rr.rdata_0), 32'h00ABCDEF);
    chk("r0_mem_addr_hold", 32'(if_rr.mem_addr_b), 32'h10);

    // Sin window read returns zero with err_unmapped
    if_rr.req_1 = 1'b1; if_rr.addr_1 = 17'd90150; #1;
    chk("sin_gnt_1", 32'(if_rr.gnt_1), 32'd1);
    cyc(); if_rr.req_1 = 1'b0;
    cyc(); #1;
    chk("sin_rvalid_1", 32'(if_rr.rvalid_1), 32'd1);
    chk("sin_rdata_1", 32'(if_rr.rdata_1), 32'd0);
    chk("sin_err", 32'(if_rr.err_unmapped), 32'd1);
    chk("sin_rdata_0_hold", 32'(if_rr.rdata_0), 32'h00ABCDEF);

    // First RAM address is a normal read
    cyc(); if_rr.req_0 = 1'b1; if_rr.addr_0 = 17'd90300; #1;
    chk("ram_gnt_0", 32'(if_rr.gnt_0), 32'd1);
    chk("ram_err_clear", 32'(if_rr.err_unmapped), 32'd0);
    cyc(); if_rr.req_0 = 1'b0;
    cyc(); #1;
    chk("ram_rvalid_0", 32'(if_rr.rvalid_0), 32'd1);
    chk("ram_rdata_0", 32'(if_rr.rdata_0), 32'h00AD2E9B);
    chk("ram_err", 32'(if_rr.err_unmapped), 32'd0);

    // Two reads in flight, then reset drops both
    cyc(); if_rr.req_0 = 1'b1; if_rr.addr_0 = 17'h00020; #1;
    chk("mid_gnt_0", 32'(if_rr.gnt_0), 32'd1);
    cyc(); if_rr.req_0 = 1'b0; if_rr.req_1 = 1'b1; if_rr.addr_1 = 17'h00030; #1;
    chk("mid_gnt_1", 32'(if_rr.gnt_1), 32'd1);
    cyc(); rst = 1'b1; if_rr.req_0 = 1'b1; if_rr.req_1 = 1'b1; #1;
    chk("mid_rst_gnt_0", 32'(if_rr.gnt_0), 32'd0);
    chk("mid_rst_gnt_1", 32'(if_rr.gnt_1), 32'd0);
    chk("mid_rst_rvalid_0", 32'(if_rr.rvalid_0), 32'd0);
    cyc(); rst = 1'b0; if_rr.addr_0 = 17'h00060; if_rr.addr_1 = 17'h00070; #1;
    chk("post_rst_rvalid_1", 32'(if_rr.rvalid_1), 32'd0);
    chk("post_rst_gnt_0", 32'(if_rr.gnt_0), 32'd1);
    chk("post_rst_gnt_1", 32'(if_rr.gnt_1), 32'd0);
    cyc(); if_rr.req_0 = 1'b0; if_rr.req_1 = 1'b0; #1;
    chk("post_rst_idle_0", 32'(if_rr.rvalid_0), 32'd0);
    chk("post_rst_idle_1", 32'(if_rr.rvalid_1), 32'd0);
    cyc(); #1;
    chk("post_rst_rvalid_0", 32'(if_rr.rvalid_0), 32'd1);
    chk("post_rst_rdata_0", 32'(if_rr.rdata_0), 32'h00ABCE3F);

    // Fixed priority: requester 1 alone goes straight through
    cyc(); if_fp.req_1 = 1'b1; if_fp.addr_1 = 17'h00050; #1;
    chk("fp_solo_gnt_1", 32'(if_fp.gnt_1), 32'd1);
    cyc(); if_fp.req_1 = 1'b0;
    cyc(); #1;
    chk("fp_solo_rvalid_1", 32'(if_fp.rvalid_1), 32'd1);
    chk("fp_solo_rdata_1", 32'(if_fp.rdata_1), 32'h00ABCE2F);

    // Both held: 0,0,0,1 repeating with MAX_WAIT=3
    for (int i = 0; i < 10; i++) begin
      cyc();
      if_fp.req_0 = (i < 8); if_fp.req_1 = (i < 8);
      if_fp.addr_0 = 17'h00040; if_fp.addr_1 = 17'h00050; #1;
      chk("fp_gnt_0", 32'(if_fp.gnt_0), 32'((i < 8) && (i % 4 != 3)));
      chk("fp_gnt_1", 32'(if_fp.gnt_1), 32'((i < 8) && (i % 4 == 3)));
      chk("fp_rvalid_0", 32'(if_fp.rvalid_0), 32'((i >= 2) && ((i - 2) % 4 != 3)));
      chk("fp_rvalid_1", 32'(if_fp.rvalid_1), 32'((i >= 2) && ((i - 2) % 4 == 3)));
      if (i >= 2 && (i - 2) % 4 != 3) chk("fp_rdata_0", 32'(if_fp.rdata_0), 32'h00ABCE1F);
      if (i >= 2 && (i - 2) % 4 == 3) chk("fp_rdata_1", 32'(if_fp.rdata_1), 32'h00ABCE2F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/port_b_arbiter.md
# port_b_arbiter

Shares the memory stage's read-only port B (image ROM and data RAM, 24-bit words, 17-bit unified address) between two requesters: requester 0 (VGA pixel fetch) and requester 1 (debug/UART dump). It runs on a single clock and grants at most one read per cycle. It tracks each in-flight read through the port's fixed registered read latency and routes the returned word back to the requester that issued it. It also flags reads that hit the sin-ROM window, which port B does not serve.

## Interface
- ADDR_W, 17: unified memory address width.
- DATA_W, 24: read data width.
- RD_LATENCY, 2: cycles from the grant cycle to valid `mem_rdata_b`. Covers the port's input and output registers; legal range 1..4.
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, requester 0 wins.
- MAX_WAIT, 15: in PRIO_MODE=1, the number of consecutive cycles requester 1 may be refused before it is forced through; legal range 1..255.
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- req_0 / req_1, in, 1: read request; held until granted.
- addr_0 / addr_1, in, ADDR_W: read address; stable while req is high.
- gnt_0 / gnt_1, out, 1: combinational grant; the transfer occurs in a cycle where req && gnt.
- rvalid_0 / rvalid_1, out, 1: one-cycle pulse; read data valid.
- rdata_0 / rdata_1, out, DATA_W: returned word, valid only with rvalid.
- mem_addr_b, out, ADDR_W: drives the memory stage address_b.
- mem_rdata_b, in, DATA_W: the memory stage read_data_b.
- err_unmapped, out, 1: one-cycle pulse, aligned with the rvalid of a read whose address is in 90000..90299.

## Operation
- Arbitration is evaluated every cycle, with at most one of gnt_0/gnt_1 high. A grant is never given without the matching req.
- PRIO_MODE=0:
  - If exactly one requester is asking, it is granted.
  - If both are asking, the requester not granted last is granted.
  - `last_gnt` updates only on a transfer.
- PRIO_MODE=1:
  - req_0 wins by default.
  - `wait_cnt` (8 bit) increments each cycle in which req_1 is high and not granted.
  - When wait_cnt == MAX_WAIT, req_1 is granted that cycle and wait_cnt clears.
  - wait_cnt also clears on any req_1 grant or whenever req_1 is low.
- mem_addr_b = the granted address in a transfer cycle. Otherwise it holds its previous registered value, so that port B sees no spurious toggling.
- Tag pipeline: RD_LATENCY stages of {valid, id, unmapped}.
  - Stage 0 is loaded on a transfer.
  - The last stage drives the rvalid of the matching id and copies mem_rdata_b to that requester's rdata.
  - rdata of the non-target requester holds its previous value.
- Unmapped window 90000..90299:
  - The read is still granted and completes with normal latency.
  - rdata is forced to 0 and err_unmapped pulses with rvalid.
- Every other address is passed through unchanged; region decode and offset subtraction stay in the memory stage.
- Reset values: gnt_* 0; rvalid_* 0; rdata_* 0; err_unmapped 0; mem_addr_b 0; last_gnt = 1 (so requester 0 wins the first tie); wait_cnt 0; all tag stages invalid.
- Reset mid-operation:
  - While rst is high, gnt_* are forced to 0.
  - Every in-flight tag is dropped; no rvalid is produced from the cycle after rst rises until a new read completes.

## Timing
- A request is granted in the same cycle it is raised if it wins arbitration. Zero-cycle grant latency.
- Throughput is one read per cycle: back-to-back reads from the same or alternating requesters may be issued on consecutive cycles.
- rvalid_x asserts exactly RD_LATENCY cycles after the grant cycle; responses return in issue order.
- A request that is both granted and deasserted in the same cycle completes normally.
- Simultaneous events:
  - A new grant, a return pulse and a wait_cnt saturation can all occur in one cycle without interaction.
  - A forced req_1 grant pre-empts req_0 for that one cycle only.

## Structure
- Shared package `mem_map_pkg` holds:
  - constants IMG_ROM_LAST = 89999, SIN_FIRST = 90000, SIN_LAST = 90299, RAM_BASE = 90300, ADDR_W, DATA_W;
  - typedef `rd_tag_t` = {valid, id, unmapped}.
- One sub-module, `rd_tag_pipe`: a parameterized RD_LATENCY-deep shift register of rd_tag_t with synchronous clear.
- Arbitration, wait counter and return routing live in port_b_arbiter.

## Test plan
- Requester 0 alone, addr 0x00010, memory model returns 0xABCDEF two cycles later → gnt_0 in the request cycle; rvalid_0 exactly 2 cycles later with rdata_0 = 0xABCDEF; rvalid_1 stays 0.
- PRIO_MODE=0, req_0 and req_1 held high for 6 cycles → grants alternate 0,1,0,1,0,1; each rvalid returns the matching word in order.
- PRIO_MODE=1, MAX_WAIT=3, both held high → gnt_0 for 3 cycles, gnt_1 on the 4th, then the pattern repeats; wait_cnt never exceeds 3.
- req_1 at addr 90150 → rvalid_1 after 2 cycles with rdata_1 = 0 and err_unmapped = 1. A read at 90300 → normal data, err_unmapped = 0.
- Reads issued on cycles 10 and 11, rst high on cycle 12 → no rvalid on cycles 12–13. After rst falls, a new read completes normally with requester 0 winning the first tie.
